// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//
// Read-side consumer for the asynchronous FIFO, running entirely in the FIFO read
// clock domain. It waits until enough words are buffered (or a partial burst has
// waited TIMEOUT cycles), latches a burst length, then issues FIFO reads. The data
// returns one cycle after each read and goes into a 2-entry skid buffer. That data
// leaves as a valid/ready stream framed with start/end-of-burst markers.
//
// Ports:
//   clk        FIFO read clock
//   rst        synchronous active-high reset
//   empty      FIFO empty flag
//   rd_usedw   FIFO read-side occupancy
//   data_out   FIFO read data, valid the cycle after an accepted read
//   rd_en      FIFO read enable (combinational)
//   m_valid    output word valid
//   m_ready    downstream accept
//   m_data     output word
//   m_sop      first word of burst
//   m_eop      last word of burst
//   busy       high whenever a burst is in progress
//   burst_len  length of current/last burst
module fifo_burst_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PTRWIDTH  = 4,
    parameter int unsigned MIN_BURST = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                empty,
    input  logic [PTRWIDTH:0]   rd_usedw,
    input  logic [WIDTH-1:0]    data_out,
    output logic                rd_en,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_sop,
    output logic                m_eop,
    output logic                busy,
    output logic [PTRWIDTH:0]   burst_len
);

    localparam int unsigned CntW   = PTRWIDTH + 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT + 2);

    localparam logic [CntW-1:0]   MinBurst   = CntW'(MIN_BURST);
    localparam logic [CntW-1:0]   MaxBurst   = CntW'(MAX_BURST);
    localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [CntW-1:0]     remaining_q, remaining_d;
    logic [CntW-1:0]     burst_len_q, burst_len_d;
    logic [CntW-1:0]     cap_cnt_q, cap_cnt_d;
    logic                inflight_q;

    // 2-entry output buffer
    logic [WIDTH-1:0]    buf_data_q [2];
    logic                buf_sop_q  [2];
    logic                buf_eop_q  [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          occ_q, occ_d;

    logic                start;
    logic [CntW-1:0]     start_len;
    logic [1:0]          occ_sum;
    logic                room;
    logic                push, pop;
    logic                push_sop, push_eop;

    assign push = inflight_q;
    assign pop  = m_valid && m_ready;

    // Words already committed downstream: buffered plus the one returning this cycle.
    assign occ_sum = occ_q + {1'b0, inflight_q};
    assign room    = (occ_sum < 2'd2) || ((occ_sum == 2'd2) && pop);

    assign start     = !empty && (rd_usedw != '0) &&
                       ((rd_usedw >= MinBurst) || (timer_q == TimeoutVal));
    assign start_len = (rd_usedw > MaxBurst) ? MaxBurst : rd_usedw;

    assign push_sop = (cap_cnt_q == '0);
    assign push_eop = ((cap_cnt_q + CntW'(1)) == burst_len_q);

    assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        burst_len_d = burst_len_q;
        cap_cnt_d   = cap_cnt_q;
        rd_en       = 1'b0;

        if (push) begin
            cap_cnt_d = cap_cnt_q + CntW'(1);
        end

        case (state_q)
            StIdle: begin
                if (empty || (rd_usedw >= MinBurst)) begin
                    timer_d = '0;
                end else if (timer_q != TimeoutVal) begin
                    timer_d = timer_q + TimerW'(1);
                end
                if (start) begin
                    state_d     = StRead;
                    burst_len_d = start_len;
                    remaining_d = start_len;
                    cap_cnt_d   = '0;
                    timer_d     = '0;
                end
            end
            StRead: begin
                // A transient empty only pauses issue; the latched length stands.
                rd_en = (remaining_q != '0) && !empty && room;
                if (rd_en) begin
                    remaining_d = remaining_q - CntW'(1);
                    if (remaining_q == CntW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && m_eop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            remaining_q <= '0;
            burst_len_q <= '0;
            cap_cnt_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            burst_len_q <= burst_len_d;
            cap_cnt_q   <= cap_cnt_d;
            inflight_q  <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_sop_q[0]  <= 1'b0;
            buf_sop_q[1]  <= 1'b0;
            buf_eop_q[0]  <= 1'b0;
            buf_eop_q[1]  <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= data_out;
                buf_sop_q[wr_ptr_q]  <= push_sop;
                buf_eop_q[wr_ptr_q]  <= push_eop;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf_data_q[rd_ptr_q];
    assign m_sop     = m_valid && buf_sop_q[rd_ptr_q];
    assign m_eop     = m_valid && buf_eop_q[rd_ptr_q];
    assign busy      = (state_q != StIdle);
    assign burst_len = burst_len_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader. Instance 0: MIN_BURST=4, MAX_BURST=8, TIMEOUT=15.
// Instance 1: MIN_BURST=4, MAX_BURST=16, TIMEOUT=0. Each has a behavioural FIFO
// read side. Expected words go on a queue when preloaded; accepted words are
// recorded by a monitor and compared by the scenario tasks.
module tb_fifo_burst_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic [31:0] cyc;
    } beat_t;

    // ---------------- instance 0 ----------------
    logic       rst0 = 1'b1;
    logic       empty0;
    logic [4:0] usedw0;
    logic [7:0] dout0 = 8'h00;
    logic       rd_en0, m_valid0, m_sop0, m_eop0, busy0;
    logic       m_ready0 = 1'b1;
    logic [7:0] m_data0;
    logic [4:0] blen0;

    logic [7:0] mem0 [64];
    int wr0 = 0;
    int rd0 = 0;
    assign empty0 = (wr0 == rd0);
    assign usedw0 = 5'(wr0 - rd0);
    always @(posedge clk) begin
        if (rd_en0 && (wr0 != rd0)) begin
            dout0 <= mem0[rd0 % 64];
            rd0   <= rd0 + 1;
        end
    end

    fifo_burst_reader #(
        .WIDTH(8), .PTRWIDTH(4), .MIN_BURST(4), .MAX_BURST(8), .TIMEOUT(15)
    ) dut0 (
        .clk(clk), .rst(rst0), .empty(empty0), .rd_usedw(usedw0), .data_out(dout0),
        .rd_en(rd_en0), .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0),
        .m_sop(m_sop0), .m_eop(m_eop0), .busy(busy0), .burst_len(blen0)
    );

    // ---------------- instance 1 ----------------
    logic       rst1 = 1'b1;
    logic       empty1;
    logic [4:0] usedw1;
    logic [7:0] dout1 = 8'h00;
    logic       rd_en1, m_valid1, m_sop1, m_eop1, busy1;
    logic       m_ready1 = 1'b1;
    logic [7:0] m_data1;
    logic [4:0] blen1;

    logic [7:0] mem1 [64];
    int wr1 = 0;
    int rd1 = 0;
    assign empty1 = (wr1 == rd1);
    assign usedw1 = 5'(wr1 - rd1);
    always @(posedge clk) begin
        if (rd_en1 && (wr1 != rd1)) begin
            dout1 <= mem1[rd1 % 64];
            rd1   <= rd1 + 1;
        end
    end

    fifo_burst_reader #(
        .WIDTH(8), .PTRWIDTH(4), .MIN_BURST(4), .MAX_BURST(16), .TIMEOUT(0)
    ) dut1 (
        .clk(clk), .rst(rst1), .empty(empty1), .rd_usedw(usedw1), .data_out(dout1),
        .rd_en(rd_en1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .m_sop(m_sop1), .m_eop(m_eop1), .busy(busy1), .burst_len(blen1)
    );

    // ---------------- monitors (record only) ----------------
    beat_t obs0[$], exp0[$], obs1[$], exp1[$];
    beat_t mb0, mb1;
    int iss0 = 0, acc0 = 0, stall_err0 = 0, out_err0 = 0;
    int iss1 = 0, acc1 = 0, stall_err1 = 0, out_err1 = 0;
    logic stalled0 = 1'b0, stalled1 = 1'b0;
    logic [9:0] held0, held1;

    always @(negedge clk) begin
        #2;
        if (rst0) begin
            iss0 = 0; acc0 = 0; stalled0 = 1'b0;
        end else begin
            if (iss0 - acc0 > 2) out_err0++;
            if (stalled0 && (!m_valid0 || {m_data0, m_sop0, m_eop0} != held0)) stall_err0++;
            stalled0 = m_valid0 && !m_ready0;
            held0    = {m_data0, m_sop0, m_eop0};
            if (rd_en0 && !empty0) iss0++;
            if (m_valid0 && m_ready0) begin
                acc0++;
                mb0.data = m_data0; mb0.sop = m_sop0; mb0.eop = m_eop0; mb0.cyc = cyc;
                obs0.push_back(mb0);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst1) begin
            iss1 = 0; acc1 = 0; stalled1 = 1'b0;
        end else begin
            if (iss1 - acc1 > 2) out_err1++;
            if (stalled1 && (!m_valid1 || {m_data1, m_sop1, m_eop1} != held1)) stall_err1++;
            stalled1 = m_valid1 && !m_ready1;
            held1    = {m_data1, m_sop1, m_eop1};
            if (rd_en1 && !empty1) iss1++;
            if (m_valid1 && m_ready1) begin
                acc1++;
                mb1.data = m_data1; mb1.sop = m_sop1; mb1.eop = m_eop1; mb1.cyc = cyc;
                obs1.push_back(mb1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load0(input logic [7:0] d, input logic sop, input logic eop);
        beat_t e;
        mem0[wr0 % 64] = d;
        wr0++;
        e.data = d; e.sop = sop; e.eop = eop; e.cyc = '0;
        exp0.push_back(e);
    endtask

    task automatic load1(input logic [7:0] d, input logic sop, input logic eop);
        beat_t e;
        mem1[wr1 % 64] = d;
        wr1++;
        e.data = d; e.sop = sop; e.eop = eop; e.cyc = '0;
        exp1.push_back(e);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) tick();
        rst0 = 1'b0; rst1 = 1'b0;
        n_tests++; if (rd_en0 !== 1'b0) begin n_fail++;
            $display("FAIL reset_rd_en: got %b want 0", rd_en0); end
        n_tests++; if (m_valid0 !== 1'b0) begin n_fail++;
            $display("FAIL reset_m_valid: got %b want 0", m_valid0); end
        n_tests++; if (m_data0 !== 8'h00) begin n_fail++;
            $display("FAIL reset_m_data: got %h want 00", m_data0); end
        n_tests++; if ({m_sop0, m_eop0} !== 2'b00) begin n_fail++;
            $display("FAIL reset_sop_eop: got %b want 00", {m_sop0, m_eop0}); end
        n_tests++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b%b want 00", busy0, busy1); end
        n_tests++; if (blen0 !== 5'd0) begin n_fail++;
            $display("FAIL reset_burst_len: got %0d want 0", blen0); end
    endtask

    task automatic test_threshold();
        int base;
        beat_t e, o;
        base = obs0.size();
        for (int i = 0; i < 6; i++) load0(8'(8'h10 + i), i == 0, i == 5);
        n_tests++; if (rd_en0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++;
            $display("FAIL thr_idle: got rd_en=%b busy=%b want 0 0", rd_en0, busy0); end
        tick();
        n_tests++; if (busy0 !== 1'b1 || rd_en0 !== 1'b1) begin n_fail++;
            $display("FAIL thr_start: got busy=%b rd_en=%b want 1 1", busy0, rd_en0); end
        n_tests++; if (blen0 !== 5'd6) begin n_fail++;
            $display("FAIL thr_burst_len: got %0d want 6", blen0); end
        tick();
        n_tests++; if (m_valid0 !== 1'b0) begin n_fail++;
            $display("FAIL thr_early_valid: got %b want 0", m_valid0); end
        tick();
        n_tests++; if ({m_valid0, m_sop0, m_data0} !== {1'b1, 1'b1, 8'h10}) begin n_fail++;
            $display("FAIL thr_first_word: got v=%b sop=%b d=%h want 1 1 10",
                     m_valid0, m_sop0, m_data0); end
        for (int k = 0; k < 50 && !((obs0.size() - base) == 6 && !busy0); k++) tick();
        n_tests++;
        if ((obs0.size() - base) != 6) begin
            n_fail++;
            $display("FAIL thr_count: got %0d words want 6", obs0.size() - base);
            exp0.delete();
        end else begin
            for (int i = 0; i < 6; i++) begin
                e = exp0.pop_front(); o = obs0[base + i];
                n_tests++; if ({o.data, o.sop, o.eop} !== {e.data, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL thr_word%0d: got %h/%b/%b want %h/%b/%b", i,
                             o.data, o.sop, o.eop, e.data, e.sop, e.eop); end
            end
            n_tests++; if (obs0[base + 5].cyc - obs0[base].cyc != 5) begin n_fail++;
                $display("FAIL thr_consecutive: got span %0d want 5",
                         obs0[base + 5].cyc - obs0[base].cyc); end
        end
    endtask

    task automatic test_timeout();
        int base, early;
        beat_t e, o;
        base = obs0.size();
        early = 0;
        load0(8'h20, 1'b1, 1'b0);
        load0(8'h21, 1'b0, 1'b1);
        if (rd_en0) early++;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (rd_en0) early++;
        end
        n_tests++; if (early !== 0) begin n_fail++;
            $display("FAIL to_early_rd_en: got %0d cycles want 0", early); end
        tick();
        n_tests++; if (rd_en0 !== 1'b1 || busy0 !== 1'b1) begin n_fail++;
            $display("FAIL to_start: got rd_en=%b busy=%b want 1 1", rd_en0, busy0); end
        for (int k = 0; k < 40 && !((obs0.size() - base) == 2 && !busy0); k++) tick();
        n_tests++; if (blen0 !== 5'd2) begin n_fail++;
            $display("FAIL to_burst_len: got %0d want 2", blen0); end
        n_tests++;
        if ((obs0.size() - base) != 2) begin
            n_fail++;
            $display("FAIL to_count: got %0d words want 2", obs0.size() - base);
            exp0.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp0.pop_front(); o = obs0[base + i];
                n_tests++; if ({o.data, o.sop, o.eop} !== {e.data, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL to_word%0d: got %h/%b/%b want %h/%b/%b", i,
                             o.data, o.sop, o.eop, e.data, e.sop, e.eop); end
            end
        end
    endtask

    task automatic test_max_burst();
        int base;
        beat_t e, o;
        base = obs0.size();
        for (int i = 0; i < 16; i++) load0(8'(8'h30 + i), (i % 8) == 0, (i % 8) == 7);
        tick();
        n_tests++; if (blen0 !== 5'd8) begin n_fail++;
            $display("FAIL max_burst_len: got %0d want 8", blen0); end
        for (int k = 0; k < 200 && !((obs0.size() - base) == 16 && !busy0); k++) tick();
        n_tests++;
        if ((obs0.size() - base) != 16) begin
            n_fail++;
            $display("FAIL max_count: got %0d words want 16", obs0.size() - base);
            exp0.delete();
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = exp0.pop_front(); o = obs0[base + i];
                n_tests++; if ({o.data, o.sop, o.eop} !== {e.data, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL max_word%0d: got %h/%b/%b want %h/%b/%b", i,
                             o.data, o.sop, o.eop, e.data, e.sop, e.eop); end
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [15:0] pat;
        beat_t e, o;
        pat  = 16'b1001_1100_0101_0011;
        base = obs1.size();
        for (int i = 0; i < 10; i++) load1(8'(8'h50 + i), i == 0, i == 9);
        for (int k = 0; k < 400 && !((obs1.size() - base) == 10 && !busy1); k++) begin
            m_ready1 = pat[k % 16];
            tick();
        end
        m_ready1 = 1'b1;
        n_tests++; if (blen1 !== 5'd10) begin n_fail++;
            $display("FAIL bp_burst_len: got %0d want 10", blen1); end
        n_tests++; if (stall_err1 !== 0) begin n_fail++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err1); end
        n_tests++; if (out_err1 !== 0) begin n_fail++;
            $display("FAIL bp_outstanding: got %0d overruns want 0", out_err1); end
        n_tests++;
        if ((obs1.size() - base) != 10) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words want 10", obs1.size() - base);
            exp1.delete();
        end else begin
            for (int i = 0; i < 10; i++) begin
                e = exp1.pop_front(); o = obs1[base + i];
                n_tests++; if ({o.data, o.sop, o.eop} !== {e.data, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h/%b/%b want %h/%b/%b", i,
                             o.data, o.sop, o.eop, e.data, e.sop, e.eop); end
            end
        end
    endtask

    task automatic test_single_word();
        beat_t e;
        m_ready1 = 1'b1;
        load1(8'h66, 1'b1, 1'b1);
        repeat (3) tick();
        e = exp1.pop_front();
        n_tests++;
        if ({m_valid1, m_data1, m_sop1, m_eop1} !== {1'b1, e.data, e.sop, e.eop}) begin
            n_fail++;
            $display("FAIL single_word: got v=%b %h/%b/%b want 1 %h/%b/%b",
                     m_valid1, m_data1, m_sop1, m_eop1, e.data, e.sop, e.eop); end
        n_tests++; if (blen1 !== 5'd1) begin n_fail++;
            $display("FAIL single_burst_len: got %0d want 1", blen1); end
        tick();
        n_tests++; if (m_valid1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++;
            $display("FAIL single_done: got v=%b busy=%b want 0 0", m_valid1, busy1); end
    endtask

    task automatic test_reset_mid_burst();
        int base, n_pre, remain;
        beat_t e, o;
        m_ready0 = 1'b1;
        base = obs0.size();
        for (int i = 0; i < 8; i++) begin
            mem0[wr0 % 64] = 8'(8'h40 + i);
            wr0++;
        end
        for (int k = 0; k < 40 && (obs0.size() - base) < 3; k++) tick();
        rst0  = 1'b1;
        n_pre = obs0.size() - base;
        tick();
        rst0 = 1'b0;
        n_tests++; if (n_pre !== 3) begin n_fail++;
            $display("FAIL rst_pre_words: got %0d want 3", n_pre); end
        for (int i = 0; i < n_pre && i < 3; i++) begin
            o = obs0[base + i];
            n_tests++; if ({o.data, o.sop, o.eop} !== {8'(8'h40 + i), i == 0, 1'b0}) begin
                n_fail++;
                $display("FAIL rst_pre_word%0d: got %h/%b/%b want %h/%b/0", i,
                         o.data, o.sop, o.eop, 8'(8'h40 + i), i == 0); end
        end
        n_tests++;
        if ({rd_en0, m_valid0, m_data0, m_sop0, m_eop0, busy0, blen0} !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_outputs: got rd_en=%b v=%b d=%h sop=%b eop=%b busy=%b len=%0d want all 0",
                     rd_en0, m_valid0, m_data0, m_sop0, m_eop0, busy0, blen0); end
        // The new burst is whatever the FIFO still holds after the discarded reads.
        remain = wr0 - rd0;
        base   = obs0.size();
        for (int i = 0; i < remain; i++) begin
            e.data = mem0[(rd0 + i) % 64]; e.sop = (i == 0); e.eop = (i == remain - 1);
            e.cyc = '0;
            exp0.push_back(e);
        end
        for (int k = 0; k < 80 && !((obs0.size() - base) == remain && !busy0
                                    && blen0 != 5'd0); k++) tick();
        n_tests++; if (blen0 !== 5'(remain)) begin n_fail++;
            $display("FAIL rst_new_len: got %0d want %0d", blen0, remain); end
        n_tests++;
        if ((obs0.size() - base) != remain) begin
            n_fail++;
            $display("FAIL rst_new_count: got %0d want %0d", obs0.size() - base, remain);
            exp0.delete();
        end else begin
            for (int i = 0; i < remain; i++) begin
                e = exp0.pop_front(); o = obs0[base + i];
                n_tests++; if ({o.data, o.sop, o.eop} !== {e.data, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL rst_new_word%0d: got %h/%b/%b want %h/%b/%b", i,
                             o.data, o.sop, o.eop, e.data, e.sop, e.eop); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_timeout();
        test_max_burst();
        test_backpressure();
        test_single_word();
        test_reset_mid_burst();
        n_tests++; if (stall_err0 !== 0 || out_err0 !== 0) begin n_fail++;
            $display("FAIL inst0_protocol: got stall=%0d overrun=%0d want 0 0",
                     stall_err0, out_err0); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
